// File: rtl/m_avmm_sram_slave_pkg.sv
// -----------------------------------------------------------------------------
// m_avmm_sram_slave_pkg
// Shared constants for the Avalon-MM SRAM slave:
//   WORD_BITS        default data word width
//   MEM_ADDR_BITS    default bus word-address width
//   MEM_LFSR_SEED    reset value of the wait-state LFSR
//   MEM_LFSR_TAPS    feedback mask of the 8-bit Fibonacci LFSR (taps 8,6,5,4)
// plus the LFSR next-state helper used when MEM_WAIT_INJECT_EN is defined.
// -----------------------------------------------------------------------------
package m_avmm_sram_slave_pkg;

  localparam int unsigned WORD_BITS     = 32;
  localparam int unsigned MEM_ADDR_BITS = 16;

  localparam logic [7:0] MEM_LFSR_SEED = 8'hA5;
  // Tap positions 8,6,5,4 (1-based) map to bits 7,5,4,3.
  localparam logic [7:0] MEM_LFSR_TAPS = 8'b1011_1000;

  // Fibonacci step: XOR of the tapped bits shifts in at the LSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] i_state);
    logic w_fb;
    w_fb = ^(i_state & MEM_LFSR_TAPS);
    return {i_state[6:0], w_fb};
  endfunction

endpackage

// File: rtl/m_avmm_sram_slave_rd_pipe.sv
// -----------------------------------------------------------------------------
// m_rd_pipe
// Fixed-depth {valid, data} shift register that delays read data sampled from
// the array by p_stages cycles. Only the valid bits are reset; data travels
// unqualified and is masked downstream by the valid bit.
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset (clears valids)
//   i_vld    valid into stage 0
//   i_data   data into stage 0
//   o_vld    valid out of the last stage
//   o_data   data out of the last stage
// -----------------------------------------------------------------------------
module m_rd_pipe #(
  parameter int unsigned p_st_bits = 32,
  parameter int unsigned p_stages  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_vld,
  input  logic [p_st_bits-1:0] i_data,
  output logic                 o_vld,
  output logic [p_st_bits-1:0] o_data
);

  logic [p_stages-1:0]  r_vld;
  logic [p_st_bits-1:0] r_data [p_stages];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      for (int i = 1; i < int'(p_stages); i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_data[0] <= i_data;
    for (int i = 1; i < int'(p_stages); i++) begin
      r_data[i] <= r_data[i-1];
    end
  end

  assign o_vld  = r_vld[p_stages-1];
  assign o_data = r_data[p_stages-1];

endmodule

// File: rtl/m_avmm_sram_slave.sv
// -----------------------------------------------------------------------------
// m_avmm_sram_slave
// Word-addressed on-chip SRAM behind an Avalon-MM slave port with a fixed,
// pipelined read latency and a bounded number of outstanding reads.
// Optional feature macro: MEM_WAIT_INJECT_EN -- when defined, an 8-bit LFSR
// forces pseudo-random wait states (about 1 cycle in 8).
// Ports:
//   clk              clock
//   rst              asynchronous active-low reset
//   i_addr           word address; bits above p_depth_log2 alias
//   i_read           read request
//   i_write          write request (discarded when i_read is also high)
//   i_writedata      write data
//   o_waitrequest    1 = request not accepted this cycle
//   o_readdata       read data, zero unless o_readdatavalid
//   o_readdatavalid  one-cycle pulse per accepted read, p_read_latency later
// -----------------------------------------------------------------------------
module m_avmm_sram_slave
  import m_avmm_sram_slave_pkg::*;
#(
  parameter int unsigned p_st_bits         = WORD_BITS,
  parameter int unsigned p_addr_bits       = MEM_ADDR_BITS,
  parameter int unsigned p_depth_log2      = 10,
  parameter int unsigned p_read_latency    = 2,
  parameter int unsigned p_max_outstanding = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [p_addr_bits-1:0] i_addr,
  input  logic                   i_read,
  input  logic                   i_write,
  input  logic [p_st_bits-1:0]   i_writedata,
  output logic                   o_waitrequest,
  output logic [p_st_bits-1:0]   o_readdata,
  output logic                   o_readdatavalid
);

  localparam int unsigned lp_cnt_bits = $clog2(p_max_outstanding + 1);
  localparam int unsigned lp_depth    = 1 << p_depth_log2;
  localparam logic [lp_cnt_bits-1:0] lp_cnt_max = lp_cnt_bits'(p_max_outstanding);
  localparam logic [lp_cnt_bits-1:0] lp_cnt_one = lp_cnt_bits'(1);

  logic [p_st_bits-1:0]    r_mem [lp_depth];
  logic [lp_cnt_bits-1:0]  r_cnt;

  logic [p_depth_log2-1:0] w_idx;
  logic                    w_inject;
  logic                    w_full;
  logic                    w_rd_acc;
  logic                    w_wr_acc;
  logic [p_st_bits-1:0]    w_rd_data;
  logic                    w_pipe_vld;
  logic [p_st_bits-1:0]    w_pipe_data;

  // Upper address bits alias onto the array.
  assign w_idx = i_addr[p_depth_log2-1:0];

  generate
    if (p_depth_log2 < p_addr_bits) begin : g_alias
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^i_addr[p_addr_bits-1:p_depth_log2];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Wait-state source
  // ---------------------------------------------------------------------------
`ifdef MEM_WAIT_INJECT_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= MEM_LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_inject = (r_lfsr[2:0] == 3'b000);
`else
  assign w_inject = 1'b0;
`endif

  // Waitrequest depends only on registered state (and reset), never on the
  // request inputs, so the arbiter sees no combinational loop through us.
  assign w_full        = (r_cnt == lp_cnt_max);
  assign o_waitrequest = ~rst | w_full | w_inject;

  // Read has priority: a simultaneous write is dropped, not deferred.
  assign w_rd_acc = i_read & ~o_waitrequest;
  assign w_wr_acc = i_write & ~i_read & ~o_waitrequest;

  // ---------------------------------------------------------------------------
  // Array: write at the accept edge, read sampled at the accept edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_idx] <= i_writedata;
    end
  end

  assign w_rd_data = r_mem[w_idx];

  m_rd_pipe #(
    .p_st_bits (p_st_bits),
    .p_stages  (p_read_latency)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (w_rd_acc),
    .i_data (w_rd_data),
    .o_vld  (w_pipe_vld),
    .o_data (w_pipe_data)
  );

  // ---------------------------------------------------------------------------
  // Outstanding-read counter: accept and return in one cycle cancel out
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      unique case ({w_rd_acc, w_pipe_vld})
        2'b10:   r_cnt <= r_cnt + lp_cnt_one;
        2'b01:   r_cnt <= r_cnt - lp_cnt_one;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_readdatavalid = w_pipe_vld;
  assign o_readdata      = w_pipe_vld ? w_pipe_data : '0;

endmodule

// File: tb/tb_m_avmm_sram_slave.sv
module tb_m_avmm_sram_slave;

  localparam int L  = 2;
  localparam int MX = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance (max outstanding = 2)
  logic [15:0] a_addr = '0;
  logic        a_read = 1'b0, a_write = 1'b0;
  logic [31:0] a_wd = '0;
  logic        a_wait, a_vld;
  logic [31:0] a_rd;

  // Second instance (max outstanding = 1)
  logic [15:0] b_addr = '0;
  logic        b_read = 1'b0, b_write = 1'b0;
  logic [31:0] b_wd = '0;
  logic        b_wait, b_vld;
  logic [31:0] b_rd;

  m_avmm_sram_slave #(.p_max_outstanding(MX)) dut (
    .clk(clk), .rst(rst), .i_addr(a_addr), .i_read(a_read), .i_write(a_write),
    .i_writedata(a_wd), .o_waitrequest(a_wait), .o_readdata(a_rd),
    .o_readdatavalid(a_vld));

  m_avmm_sram_slave #(.p_max_outstanding(1)) dut1 (
    .clk(clk), .rst(rst), .i_addr(b_addr), .i_read(b_read), .i_write(b_write),
    .i_writedata(b_wd), .o_waitrequest(b_wait), .o_readdata(b_rd),
    .o_readdatavalid(b_vld));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int inj_cnt = 0;
  int nonfull_cnt = 0;

  // Reference model: memory contents plus a queue of pending reads.
  logic [31:0] mem_m [1024];
  bit          known [1024];
  typedef struct { logic [31:0] data; bit known; int due; } rd_t;
  rd_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bus cycle on the main instance, checked against the model.
  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input bit rd, input bit wr, input logic [15:0] addr,
                      input logic [31:0] wd, output bit acc);
    int  occ;
    bit  ev;
    int  idx;
    rd_t e;
    a_read = rd; a_write = wr; a_addr = addr; a_wd = wd;
    @(negedge clk);
    occ = q.size();
    ev  = (occ > 0) && (q[0].due == cyc);
    chk("readdatavalid", a_vld, ev);
    if (ev) begin
      if (q[0].known) chk("readdata", a_rd, q[0].data);
      void'(q.pop_front());
    end
`ifdef MEM_WAIT_INJECT_EN
    if (occ >= MX) chk("waitrequest_full", a_wait, 1);
    else begin
      nonfull_cnt++;
      if (a_wait) inj_cnt++;
    end
`else
    chk("waitrequest", a_wait, occ >= MX);
`endif
    acc = (rd | wr) && !a_wait;
    idx = int'(addr[9:0]);
    if (acc && rd) begin
      e.data = mem_m[idx]; e.known = known[idx]; e.due = cyc + L;
      q.push_back(e);
    end else if (acc && wr) begin
      mem_m[idx] = wd; known[idx] = 1'b1;
    end
    @(posedge clk); #1;
    cyc++;
    a_read = 1'b0; a_write = 1'b0;
  endtask

  // Hold a request until accepted (bounded).
  task automatic issue(input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [31:0] wd);
    bit acc = 1'b0;
    int g = 0;
    while (!acc && g < 20) begin
      step(rd, wr, addr, wd, acc);
      g++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  typedef struct {
    bit rd; bit wr; logic [15:0] addr; logic [31:0] wd;
    bit ew; bit ev; logic [31:0] ed;
  } vec_t;

  initial begin
    vec_t tbl [16];
    bit   acc;
    int   k, g, issued, returned, occ1, c;
    rd_t  q1[$];
    rd_t  e;

    for (int i = 0; i < 1024; i++) known[i] = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_waitrequest", a_wait, 1);
    chk("rst_readdatavalid", a_vld, 0);
    chk("rst_readdata", a_rd, 0);
    chk("rst_waitrequest_dut1", b_wait, 1);
    @(posedge clk); #1;
    rst = 1'b1;

`ifndef MEM_WAIT_INJECT_EN
    // Directed table: write/read-after-write, read-wins, aliasing, full window.
    tbl[0]  = '{1'b0, 1'b1, 16'd5,     32'h1234, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 16'd5,     32'h0,    1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 16'd0,     32'h0,    1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 16'd0,     32'h0,    1'b0, 1'b1, 32'h1234};
    tbl[4]  = '{1'b0, 1'b1, 16'd3,     32'h55,   1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 16'd3,     32'hFF,   1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 16'd0,     32'h0,    1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 16'd3,     32'h0,    1'b0, 1'b1, 32'h55};
    tbl[8]  = '{1'b0, 1'b0, 16'd0,     32'h0,    1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 16'd0,     32'h0,    1'b0, 1'b1, 32'h55};
    tbl[10] = '{1'b1, 1'b0, 16'h0405,  32'h0,    1'b0, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 16'd3,     32'h0,    1'b0, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 16'd3,     32'h0,    1'b1, 1'b1, 32'h1234};
    tbl[13] = '{1'b1, 1'b0, 16'd3,     32'h0,    1'b0, 1'b1, 32'h55};
    tbl[14] = '{1'b0, 1'b0, 16'd0,     32'h0,    1'b0, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 1'b0, 16'd0,     32'h0,    1'b0, 1'b1, 32'h55};
    for (int i = 0; i < 16; i++) begin
      a_read = tbl[i].rd; a_write = tbl[i].wr; a_addr = tbl[i].addr; a_wd = tbl[i].wd;
      @(negedge clk);
      chk($sformatf("tbl%0d_waitrequest", i), a_wait, tbl[i].ew);
      chk($sformatf("tbl%0d_readdatavalid", i), a_vld, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_readdata", i), a_rd, tbl[i].ed);
      @(posedge clk); #1;
    end
    a_read = 1'b0; a_write = 1'b0;
    repeat (3) step(0, 0, 0, 0, acc);
`endif

    // Fill 0..7 then stream reads over them in order
    for (int i = 0; i < 8; i++) issue(0, 1, 16'(i), 32'hA0 + 32'(i));
    k = 0; g = 0;
    while (k < 8 && g < 60) begin
      step(1, 0, 16'(k), 0, acc);
      if (acc) k++;
      g++;
    end
    if (k < 8) chk("stream_timeout", 32'(k), 8);
    repeat (L + 1) step(0, 0, 0, 0, acc);
    chk("stream_drained", q.size(), 0);

    // Single-outstanding instance: never more than one read in flight
    for (int i = 0; i < 4; i++) begin
      g = 0; acc = 1'b0;
      while (!acc && g < 20) begin
        b_write = 1'b1; b_addr = 16'(i); b_wd = 32'hB0 + 32'(i);
        @(negedge clk);
        acc = !b_wait;
        @(posedge clk); #1;
        g++;
      end
      b_write = 1'b0;
      if (!acc) chk("dut1_write_timeout", 0, 1);
    end
    issued = 0; returned = 0; c = 0;
    while (returned < 4 && c < 60) begin
      b_read = (issued < 4); b_addr = 16'(issued);
      @(negedge clk);
      occ1 = q1.size();
      if (occ1 > 1) chk("dut1_outstanding", 32'(occ1), 1);
      if (occ1 > 0 && q1[0].due == c) begin
        chk("dut1_readdatavalid", b_vld, 1);
        chk("dut1_readdata", b_rd, q1[0].data);
        void'(q1.pop_front());
        returned++;
      end else begin
        chk("dut1_readdatavalid", b_vld, 0);
      end
`ifdef MEM_WAIT_INJECT_EN
      if (occ1 >= 1) chk("dut1_waitrequest_full", b_wait, 1);
`else
      chk("dut1_waitrequest", b_wait, occ1 >= 1);
`endif
      if (b_read && !b_wait) begin
        e.data = 32'hB0 + 32'(issued); e.known = 1'b1; e.due = c + L;
        q1.push_back(e);
        issued++;
      end
      @(posedge clk); #1;
      c++;
    end
    b_read = 1'b0;
    chk("dut1_returns", 32'(returned), 4);

    // Reset with two reads in flight drops them
    issue(1, 0, 16'd1, 0);
    issue(1, 0, 16'd2, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_waitrequest", a_wait, 1);
    chk("midrst_readdatavalid", a_vld, 0);
    chk("midrst_readdata", a_rd, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    cyc++;
`ifndef MEM_WAIT_INJECT_EN
    @(negedge clk);
    chk("postrst_waitrequest", a_wait, 0);
    @(posedge clk); #1;
    cyc++;
`endif
    repeat (4) step(0, 0, 0, 0, acc);

    // Randomised traffic against the model
    for (int i = 0; i < 32; i++) issue(0, 1, 16'(i), $urandom);
    inj_cnt = 0; nonfull_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'(($urandom_range(0, 63) << 10) | $urandom_range(0, 31)),
           $urandom, acc);
    end
    repeat (L + 1) step(0, 0, 0, 0, acc);
    chk("random_drained", q.size(), 0);
`ifdef MEM_WAIT_INJECT_EN
    chk("inject_duty", (inj_cnt * 100 >= nonfull_cnt * 8) &&
                       (inj_cnt * 100 <= nonfull_cnt * 17), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
